// File: rtl/serial_deserializer_pkg.sv
// Shared types and constants for the serial deserializer and its capture register.
package serial_deserializer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Same bit-order meaning as the transmitting shift register's DIR input
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial-in / parallel-out bundle between a stream source/consumer and the deserializer.
interface serial_deserializer_if
  import serial_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             ENB;
  logic             START;
  logic             DIR;
  logic             S_IN;
  logic             ACK;
  logic [WIDTH-1:0] Q;
  logic             VALID;
  logic             BUSY;
  logic             OVERRUN;

  modport master (
    output ENB, START, DIR, S_IN, ACK,
    input  Q, VALID, BUSY, OVERRUN
  );

  modport slave (
    input  ENB, START, DIR, S_IN, ACK,
    output Q, VALID, BUSY, OVERRUN
  );

endinterface

// File: rtl/serial_deserializer_capture_reg.sv
// WIDTH-bit capture shift register; exposes the post-shift word so the last
// bit can be forwarded to the output stage on the same edge it is sampled.
module serial_capture_reg
  import serial_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
  input  logic             din,
  output logic [WIDTH-1:0] word_next_s
);

  logic [WIDTH-1:0] shreg_r;

  // Next shift-register value for the latched bit order
  always_comb begin
    word_next_s = shreg_r;
    if (dir == DIR_MSB_FIRST) begin
      word_next_s = {shreg_r[WIDTH-2:0], din};
    end else begin
      word_next_s = {din, shreg_r[WIDTH-1:1]};
    end
  end

  // Shift register storage
  always_ff @(posedge clk) begin
    if (clr) begin
      shreg_r <= {WIDTH{1'b0}};
    end else if (en) begin
      shreg_r <= word_next_s;
    end else begin
      shreg_r <= shreg_r;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Framed serial-to-parallel receiver: FSM, bit counter and a VALID/ACK output
// stage with a sticky overrun flag.
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CW    = $clog2(WIDTH)
) (
  input logic                 clk,
  input logic                 RST,
  serial_deserializer_if.slave bus
);

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_r;
  state_e           state_s;
  logic [CW-1:0]    cnt_r;
  logic             dir_r;
  logic [WIDTH-1:0] q_r;
  logic             valid_r;
  logic             overrun_r;
  logic             start_acc_s;
  logic             capture_s;
  logic             done_s;
  logic [WIDTH-1:0] word_next_s;

  // Next-state and per-cycle strobes
  always_comb begin
    state_s     = state_r;
    start_acc_s = 1'b0;
    capture_s   = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.ENB && bus.START) begin
          state_s     = ST_SHIFT;
          start_acc_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.ENB) begin
          capture_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_SHIFT;
          end
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Bit counter and bit order latched at frame start
  always_ff @(posedge clk) begin
    if (RST) begin
      cnt_r <= {CW{1'b0}};
      dir_r <= DIR_MSB_FIRST;
    end else if (start_acc_s) begin
      cnt_r <= {CW{1'b0}};
      dir_r <= bus.DIR;
    end else if (done_s) begin
      cnt_r <= {CW{1'b0}};
    end else if (capture_s) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  serial_capture_reg #(
    .WIDTH(WIDTH)
  ) u_capture (
    .clk         (clk),
    .clr         (RST | start_acc_s),
    .en          (capture_s),
    .dir         (dir_r),
    .din         (bus.S_IN),
    .word_next_s (word_next_s)
  );

  // Output handshake: a completing word replaces Q only if Q is free or being acked
  always_ff @(posedge clk) begin
    if (RST) begin
      q_r       <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else if (done_s) begin
      if (!valid_r || bus.ACK) begin
        q_r     <= word_next_s;
        valid_r <= 1'b1;
      end else begin
        overrun_r <= 1'b1;
      end
    end else if (valid_r && bus.ACK) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign bus.Q       = q_r;
  assign bus.VALID   = valid_r;
  assign bus.BUSY    = (state_r == ST_SHIFT);
  assign bus.OVERRUN = overrun_r;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer: expected words queued as frames are driven.
module tb_serial_deserializer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic RST = 1'b0;

  serial_deserializer_if #(.WIDTH(W)) bus ();

  serial_deserializer #(.WIDTH(W)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_q;
  logic         m_valid;
  logic         m_overrun;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // seq[W-1] is the first bit sent on the wire
  function automatic logic [W-1:0] expect_word(input logic dir, input logic [W-1:0] seq);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) begin
      if (dir == 1'b0) w[W-1-i] = seq[W-1-i];
      else             w[i]     = seq[W-1-i];
    end
    return w;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, bus.VALID, m_valid);
    check({tag, "_overrun"}, bus.OVERRUN, m_overrun);
    check({tag, "_busy"}, bus.BUSY, 1'b0);
    if (exp_q.size() > 0) m_q = exp_q.pop_front();
    check({tag, "_q"}, bus.Q, m_q);
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b1;
    @(posedge clk); #1;
    RST = 1'b0;
    m_q = '0; m_valid = 1'b0; m_overrun = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_ack(input string tag);
    bus.ACK = 1'b1;
    @(posedge clk); #1;
    bus.ACK = 1'b0;
    if (m_valid) m_valid = 1'b0;
    @(negedge clk);
    check_outputs(tag);
  endtask

  // Entered away from a clock edge; returns at the negedge after completion
  task automatic run_frame(input string tag, input logic dir, input logic [W-1:0] seq,
                           input int stall_after, input int stall_len,
                           input logic toggle_dir, input logic ack_last);
    logic [W-1:0] w;
    w = expect_word(dir, seq);
    bus.START = 1'b1; bus.ENB = 1'b1; bus.DIR = dir; bus.S_IN = ~seq[W-1];
    @(posedge clk); #1;
    bus.START = 1'b0;
    for (int i = 0; i < W; i++) begin
      bus.S_IN = seq[W-1-i];
      if (toggle_dir) bus.DIR = ~bus.DIR;
      if (i == W-1) bus.ACK = ack_last;
      @(negedge clk);
      check({tag, "_busy_bit"}, bus.BUSY, 1'b1);
      if (i == W-1) check({tag, "_valid_pre"}, bus.VALID, m_valid);
      @(posedge clk); #1;
      if (i == stall_after-1 && stall_len > 0) begin
        bus.ENB = 1'b0; bus.START = 1'b1; bus.S_IN = ~seq[W-2-i];
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check({tag, "_busy_stall"}, bus.BUSY, 1'b1);
          @(posedge clk); #1;
        end
        bus.ENB = 1'b1; bus.START = 1'b0;
      end
    end
    bus.ACK = 1'b0;
    if (!m_valid) begin
      exp_q.push_back(w);
      m_valid = 1'b1;
    end else if (ack_last) begin
      exp_q.push_back(w);
    end else begin
      m_overrun = 1'b1;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sr;
    logic [W-1:0] lb;
    bus.ENB = 1'b0; bus.START = 1'b0; bus.DIR = 1'b0; bus.S_IN = 1'b0; bus.ACK = 1'b0;
    m_q = '0; m_valid = 1'b0; m_overrun = 1'b0;
    @(negedge clk);
    do_reset("reset");

    run_frame("msb_1010", 1'b0, 4'b1010, 0, 0, 1'b0, 1'b0);
    check("lit_msb_1010", bus.Q, 4'b1010);
    do_ack("ack1");

    run_frame("lsb_1010", 1'b1, 4'b1010, 0, 0, 1'b1, 1'b0);
    check("lit_lsb_0101", bus.Q, 4'b0101);
    do_ack("ack2");

    run_frame("stall_1101", 1'b0, 4'b1101, 2, 2, 1'b0, 1'b0);
    check("lit_1101", bus.Q, 4'b1101);
    do_ack("ack3");

    // START while ENB=0 in IDLE is ignored
    bus.ENB = 1'b0; bus.START = 1'b1;
    @(posedge clk); #1;
    bus.START = 1'b0; bus.ENB = 1'b1;
    @(negedge clk);
    check("start_enb0_busy", bus.BUSY, 1'b0);

    run_frame("b2b_1100", 1'b0, 4'b1100, 0, 0, 1'b0, 1'b0);
    run_frame("b2b_0011", 1'b0, 4'b0011, 0, 0, 1'b0, 1'b0);
    check("lit_overrun_q", bus.Q, 4'b1100);
    check("lit_overrun", bus.OVERRUN, 1'b1);

    // Abort mid-frame after two bits
    bus.START = 1'b1; bus.ENB = 1'b1; bus.DIR = 1'b0;
    @(posedge clk); #1;
    bus.START = 1'b0; bus.S_IN = 1'b1;
    @(posedge clk); #1;
    bus.S_IN = 1'b1;
    @(posedge clk); #1;
    do_reset("abort");
    run_frame("post_abort_0110", 1'b0, 4'b0110, 0, 0, 1'b0, 1'b0);
    check("lit_0110", bus.Q, 4'b0110);
    do_ack("ack4");

    run_frame("b2b_ack_1100", 1'b0, 4'b1100, 0, 0, 1'b0, 1'b0);
    run_frame("b2b_ack_0011", 1'b0, 4'b0011, 0, 0, 1'b0, 1'b1);
    check("lit_ack_q", bus.Q, 4'b0011);
    check("lit_ack_overrun", bus.OVERRUN, 1'b0);
    do_ack("ack5");

    // Loopback from a left-rotating transmit register loaded with 1010
    sr = 4'b1010;
    for (int i = 0; i < W; i++) begin
      lb[W-1-i] = sr[W-1];
      sr = {sr[W-2:0], sr[W-1]};
    end
    run_frame("loopback", 1'b0, lb, 0, 0, 1'b0, 1'b0);
    check("lit_loopback", bus.Q, 4'b1010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
